syscall_input_responder: RTL

//  Services the input-side MIPS syscalls: read_int (v0=5) and read_char (v0=12).
//  A host or testbench streams ASCII bytes into a FIFO. On a syscall the block

---
 rtl/syscall_input_responder.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/syscall_input_responder.sv
// Input-side MIPS syscall service (read_int v0=5, read_char v0=12): byte FIFO, parser FSM, $v0 writeback.
// Optional build macro SYSCALL_ECHO_EN adds simulation echo of results and a serviced-syscall counter.
`timescale 1ns/1ps

module syscall_input_responder #(
   parameter int unsigned BUF_DEPTH = 16,
   parameter int unsigned V0_REG    = 2
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        syscall_control,
   input  logic [31:0] v0,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        stall,
   output logic        wb_en,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic        busy
);

   localparam int unsigned ADDR_W = $clog2(BUF_DEPTH);
   localparam int unsigned PTR_W  = ADDR_W + 1;

   localparam logic [31:0] CODE_READ_INT  = 32'd5;
   localparam logic [31:0] CODE_READ_CHAR = 32'd12;

   localparam logic [7:0] ASCII_SPACE = 8'h20;
   localparam logic [7:0] ASCII_LF    = 8'h0A;
   localparam logic [7:0] ASCII_MINUS = 8'h2D;
   localparam logic [7:0] ASCII_ZERO  = 8'h30;
   localparam logic [7:0] ASCII_NINE  = 8'h39;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SKIP   = 3'd1,
      DIGITS = 3'd2,
      CHAR   = 3'd3,
      WB     = 3'd4
   } state_t;

   // ---------------------------------------------------------------
   // Input byte FIFO; extra pointer bit distinguishes full from empty
   // ---------------------------------------------------------------
   logic [7:0]       mem [BUF_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   logic [7:0]       pop_byte;

   assign full     = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
   assign empty    = (wr_ptr == rd_ptr);
   assign push     = in_valid && !full;
   assign pop_byte = mem[rd_ptr[ADDR_W-1:0]];
   assign in_ready = !full;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[ADDR_W-1:0]] <= in_data;
   end

   // ---------------------------------------------------------------
   // Syscall decode and parser FSM
   // ---------------------------------------------------------------
   state_t      state;
   state_t      state_nxt;
   logic [31:0] acc;
   logic [31:0] acc_nxt;
   logic        neg;
   logic        neg_nxt;
   logic [31:0] result_nxt;
   logic        trigger;
   logic        is_ws;
   logic        is_digit;
   logic [31:0] digit;

   assign trigger  = syscall_control && (state == IDLE) &&
                     ((v0 == CODE_READ_INT) || (v0 == CODE_READ_CHAR));
   assign stall    = trigger | busy;
   assign is_ws    = (pop_byte == ASCII_SPACE) || (pop_byte == ASCII_LF);
   assign is_digit = (pop_byte >= ASCII_ZERO) && (pop_byte <= ASCII_NINE);
   assign digit    = {28'd0, pop_byte[3:0]};
   assign wb_addr  = 5'(V0_REG);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= IDLE;
         acc   <= '0;
         neg   <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         neg   <= neg_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      acc_nxt    = acc;
      neg_nxt    = neg;
      pop        = 1'b0;
      result_nxt = '0;
      case (state)
         IDLE: begin
            if (trigger) begin
               acc_nxt   = '0;
               neg_nxt   = 1'b0;
               state_nxt = (v0 == CODE_READ_CHAR) ? CHAR : SKIP;
            end
         end
         SKIP: begin
            if (!empty) begin
               pop = 1'b1;
               if (is_ws) begin
                  state_nxt = SKIP;
               end else if (pop_byte == ASCII_MINUS) begin
                  neg_nxt   = 1'b1;
                  state_nxt = DIGITS;
               end else if (is_digit) begin
                  acc_nxt   = digit;
                  state_nxt = DIGITS;
               end else begin
                  result_nxt = '0;
                  state_nxt  = WB;
               end
            end
         end
         DIGITS: begin
            if (!empty) begin
               pop = 1'b1;
               if (is_digit) begin
                  acc_nxt = (acc * 32'd10) + digit;
               end else begin
                  // terminator consumed; a lone '-' leaves acc=0 so the result is 0
                  result_nxt = neg ? (~acc + 32'd1) : acc;
                  state_nxt  = WB;
               end
            end
         end
         CHAR: begin
            if (!empty) begin
               pop        = 1'b1;
               result_nxt = {24'd0, pop_byte};
               state_nxt  = WB;
            end
         end
         WB: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Registered writeback port; wb_data only changes when a result is produced
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wb_en   <= 1'b0;
         wb_data <= '0;
         busy    <= 1'b0;
      end else begin
         wb_en <= (state_nxt == WB);
         busy  <= (state_nxt != IDLE);
         if (state_nxt == WB) wb_data <= result_nxt;
      end
   end

`ifdef SYSCALL_ECHO_EN
   localparam logic [31:0] CODE_EXIT = 32'd10;

   logic        echo_char;
   logic        exit_seen;
   int unsigned svc_count;

   // Simulation echo of each serviced syscall and a count reported at exit
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         echo_char <= 1'b0;
         exit_seen <= 1'b0;
         svc_count <= 0;
      end else begin
         if (trigger) echo_char <= (v0 == CODE_READ_CHAR);
         if (wb_en) begin
            svc_count <= svc_count + 1;
            if (echo_char) $display("read_char -> %c", wb_data[7:0]);
            else           $display("read_int -> %d", $signed(wb_data));
         end
         exit_seen <= syscall_control && (v0 == CODE_EXIT);
         if (syscall_control && (v0 == CODE_EXIT) && !exit_seen)
            $display("input syscalls serviced: %0d", svc_count);
      end
   end
`endif

endmodule
